rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Parametrised N-channel arbitrated selector with a registered output.
- Replaces the static key-selected 2:1 datapath mux.
- Selects one of NR_CH valid/ready request channels per cycle, by round-robin or fixed priority.
- Holds the winner in a one-entry output register with a valid/ready handshake.
- Sits between multiple requesters (e.g. IFU/LSU memory requests) and a single downstream port.

Parameters:
- NR_CH, 4: number of input channels, 2..16.
- DATA_LEN, 64: payload width per channel.
- CH_W, 2: width of the channel index. Must satisfy 2^CH_W >= NR_CH.
- RR_MODE, 1: arbitration mode.
  - 1 = round-robin.
  - 0 = fixed priority, lowest index wins.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NR_CH  per-channel request valid.
- in_ready  output  NR_CH  per-channel accept; combinational.
- in_data  input  NR_CH*DATA_LEN  packed payloads; channel n occupies [DATA_LEN*(n+1)-1 : DATA_LEN*n].
- out_valid  output  1  output register holds a payload.
- out_ready  input  1  downstream accepts the output.
- out_data  output  DATA_LEN  registered payload.
- out_ch  output  CH_W  registered index of the channel that supplied out_data.

Behaviour:
- Reset, asynchronous on rst_n low, effective immediately regardless of clk:
  - out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - in_ready=0 while rst_n is low.
  - A transfer in flight at reset is discarded; no partial state survives.
- Load enable: load = !out_valid | out_ready.
  - The output register can take a new entry when it is empty or is being drained in the same cycle.
- Grant, combinational, one-hot or zero:
  - RR_MODE=1: search channels starting at index rr_ptr, wrapping from NR_CH-1 to 0. The first n with in_valid[n]=1 wins.
  - RR_MODE=0: the lowest n with in_valid[n]=1 wins; rr_ptr is ignored.
- in_ready[n] = load & grant[n]. At most one in_ready bit is high in any cycle.
- Input transfer: in_valid[n] & in_ready[n] at a rising edge. On that edge:
  - out_data <= slice n of in_data.
  - out_ch <= n.
  - out_valid <= 1.
  - If RR_MODE=1: rr_ptr <= (n==NR_CH-1) ? 0 : n+1.
- Output transfer: out_valid & out_ready at a rising edge.
  - If no input transfer happens in the same cycle, out_valid <= 0.
  - out_data and out_ch keep their last value; they are don't-care while out_valid=0.
- Simultaneous drain and load: out_valid stays 1 and the new payload replaces the old on the same edge. Sustained throughput is 1 transfer/cycle.
- Latency: input transfer at edge k makes out_valid=1 with the new data visible after edge k. Minimum 1 cycle.
- Backpressure: while out_valid=1 and out_ready=0:
  - all in_ready are 0;
  - out_data, out_ch and rr_ptr are stable;
  - out_valid stays 1.
- Source rule (bench asserts it): once in_valid[n] is asserted it stays high, with in_data slice n stable, until accepted.
- rr_ptr does not move when no input transfer occurs.
- Fairness, RR_MODE=1: with all channels continuously valid and out_ready=1, grants rotate 0,1,..,NR_CH-1,0,... Any valid channel is served within NR_CH transfers.
- Widths:
  - rr_ptr is CH_W bits.
  - Index values >= NR_CH are never produced.
  - Unused high bits of out_ch are 0.
- No internal combinational path from out_ready to out_valid. out_ready to in_ready is combinational by design.

Test Plan:
- Reset mid-traffic: out_valid=1, out_data=0xAA, then rst_n=0 between edges -> out_valid=0 and out_data=0 immediately, in_ready=0; after release the first grant goes to ch0.
- Single channel: in_valid=4'b0100, in_data slice2=0x1234, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=0x1234, out_ch=2, rr_ptr=3.
- Round-robin rotation: RR_MODE=1, in_valid=4'b1111 held, out_ready=1, 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3, one output per cycle.
- Wrap search: rr_ptr=3, in_valid=4'b0011 -> ch0 granted, rr_ptr becomes 1, next grant ch1.
- Backpressure: out_valid=1 (ch1, 0x55), out_ready=0 for 5 cycles with in_valid=4'b1111 -> in_ready=0 throughout, out_data=0x55 stable; out_ready=1 -> drain and load ch2 on the same edge, out_valid stays 1.
- Fixed priority: RR_MODE=0, in_valid=4'b1010 held, out_ready=1 -> ch1 granted every cycle and ch3 starves; drop in_valid[1] -> ch3 granted the next cycle.

Source files
------------

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: request/response bundle for the N-channel arbitrated selector.
//   in_valid  [NR_CH]           per-channel request valid       (requester -> arbiter)
//   in_ready  [NR_CH]           per-channel accept, at most one (arbiter -> requester)
//   in_data   [NR_CH*DATA_LEN]  packed payloads, channel n at [DATA_LEN*n +: DATA_LEN]
//   out_valid                   output register holds a payload (arbiter -> consumer)
//   out_ready                   consumer accepts the output     (consumer -> arbiter)
//   out_data  [DATA_LEN]        registered payload
//   out_ch    [CH_W]            registered index of the supplying channel
// modport slave is the arbiter side, modport master the requester/consumer side.
interface rr_arb_mux_if #(
    parameter int unsigned NR_CH    = 4,
    parameter int unsigned DATA_LEN = 64,
    parameter int unsigned CH_W     = 2
) ();
    logic [NR_CH-1:0]          in_valid;
    logic [NR_CH-1:0]          in_ready;
    logic [NR_CH*DATA_LEN-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_LEN-1:0]       out_data;
    logic [CH_W-1:0]           out_ch;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: picks one of NR_CH valid/ready request channels per cycle and
// holds the winner in a one-entry output register with a valid/ready handshake.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_arb_mux_if.slave (in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_ch)
// RR_MODE=1: round-robin search starting at rr_ptr; RR_MODE=0: lowest index wins.
module rr_arb_mux #(
    parameter int unsigned NR_CH    = 4,
    parameter int unsigned DATA_LEN = 64,
    parameter int unsigned CH_W     = 2,
    parameter int unsigned RR_MODE  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arb_mux_if.slave  bus
);
    logic                out_valid_q, out_valid_d;
    logic [DATA_LEN-1:0] out_data_q,  out_data_d;
    logic [CH_W-1:0]     out_ch_q,    out_ch_d;
    logic [CH_W-1:0]     rr_ptr_q,    rr_ptr_d;

    logic [NR_CH-1:0]    grant;
    logic [NR_CH-1:0]    in_ready_w;
    logic [CH_W-1:0]     win;
    logic [DATA_LEN-1:0] data_sel;
    logic                found;
    logic                load;
    logic                xfer;
    int unsigned         start;

    // Circular search: first pass covers start..NR_CH-1, second pass wraps to
    // 0..start-1. Constant loop indices keep the selection purely combinational.
    always_comb begin
        grant    = '0;
        win      = '0;
        found    = 1'b0;
        data_sel = '0;
        start    = (RR_MODE != 0) ? 32'(rr_ptr_q) : 0;
        for (int unsigned n = 0; n < NR_CH; n++) begin
            if (!found && bus.in_valid[n] && (n >= start)) begin
                found    = 1'b1;
                grant[n] = 1'b1;
                win      = CH_W'(n);
            end
        end
        for (int unsigned n = 0; n < NR_CH; n++) begin
            if (!found && bus.in_valid[n] && (n < start)) begin
                found    = 1'b1;
                grant[n] = 1'b1;
                win      = CH_W'(n);
            end
        end
        for (int unsigned n = 0; n < NR_CH; n++) begin
            if (grant[n]) begin
                data_sel = bus.in_data[n*DATA_LEN +: DATA_LEN];
            end
        end
    end

    always_comb begin
        load       = !out_valid_q || bus.out_ready;
        // Gated by rst_n so no request is acknowledged while reset is held.
        in_ready_w = (rst_n && load) ? grant : '0;
        xfer       = |(bus.in_valid & in_ready_w);

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = data_sel;
            out_ch_d    = win;
            if (RR_MODE != 0) begin
                rr_ptr_d = (win == CH_W'(NR_CH - 1)) ? '0 : win + 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed bench for rr_arb_mux with one round-robin and one
// fixed-priority instance, plus a monitor that holds requesters to the rule
// that a raised in_valid stays up with stable data until accepted.
module tb_rr_arb_mux;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    rr_arb_mux_if #(.NR_CH(4), .DATA_LEN(64), .CH_W(2)) rr_if ();
    rr_arb_mux_if #(.NR_CH(4), .DATA_LEN(64), .CH_W(2)) fp_if ();

    rr_arb_mux #(.NR_CH(4), .DATA_LEN(64), .CH_W(2), .RR_MODE(1)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rr_if)
    );

    rr_arb_mux #(.NR_CH(4), .DATA_LEN(64), .CH_W(2), .RR_MODE(0)) u_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rr(input int n, input logic [63:0] v);
        rr_if.in_data[n*64 +: 64] = v;
    endtask

    task automatic set_fp(input int n, input logic [63:0] v);
        fp_if.in_data[n*64 +: 64] = v;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] ch, input logic [63:0] data);
        check({tag, "_valid"}, 64'(rr_if.out_valid), 64'd1);
        check({tag, "_ch"},    64'(rr_if.out_ch),    64'(ch));
        check({tag, "_data"},  rr_if.out_data,       data);
    endtask

    // Accept whatever is pending, retiring each channel as it is served.
    task automatic drain_rr();
        int cnt;
        cnt = 0;
        while (rr_if.in_valid != 4'b0000 && cnt < 16) begin
            step();
            rr_if.in_valid[rr_if.out_ch] = 1'b0;
            cnt++;
        end
        check("drain_budget", 64'(rr_if.in_valid), 64'd0);
    endtask

    logic [3:0]   rr_pend, fp_pend;
    logic [255:0] rr_pdata, fp_pdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_pend <= '0;
            fp_pend <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (rr_pend[n]) begin
                    check("rr_src_valid", 64'(rr_if.in_valid[n]), 64'd1);
                    check("rr_src_data", rr_if.in_data[n*64 +: 64], rr_pdata[n*64 +: 64]);
                end
                if (fp_pend[n]) begin
                    check("fp_src_valid", 64'(fp_if.in_valid[n]), 64'd1);
                    check("fp_src_data", fp_if.in_data[n*64 +: 64], fp_pdata[n*64 +: 64]);
                end
            end
            rr_pend  <= rr_if.in_valid & ~rr_if.in_ready;
            rr_pdata <= rr_if.in_data;
            fp_pend  <= fp_if.in_valid & ~fp_if.in_ready;
            fp_pdata <= fp_if.in_data;
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        rr_if.in_valid  = 4'b1111;
        rr_if.in_data   = '0;
        rr_if.out_ready = 1'b0;
        fp_if.in_valid  = 4'b0000;
        fp_if.in_data   = '0;
        fp_if.out_ready = 1'b1;

        // Reset state, requests present but held off by reset.
        #2;
        check("rst_out_valid", 64'(rr_if.out_valid), 64'd0);
        check("rst_out_data",  rr_if.out_data,       64'd0);
        check("rst_out_ch",    64'(rr_if.out_ch),    64'd0);
        check("rst_in_ready",  64'(rr_if.in_ready),  64'd0);
        check("rst_fp_valid",  64'(fp_if.out_valid), 64'd0);

        // Load 0xAA from ch0 under backpressure, then reset between edges.
        rr_if.in_valid = 4'b0001;
        set_rr(0, 64'hAA);
        rst_n = 1'b1;
        step();
        expect_out("pre_rst", 2'd0, 64'hAA);
        rr_if.in_valid = 4'b1111;
        for (int n = 0; n < 4; n++) set_rr(n, 64'h1000 + 64'(n));
        #1;
        check("bp_pre_rst_ready", 64'(rr_if.in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(rr_if.out_valid), 64'd0);
        check("midrst_data",  rr_if.out_data,       64'd0);
        check("midrst_ready", 64'(rr_if.in_ready),  64'd0);
        check("midrst_ptr",   64'(u_rr.rr_ptr_q),   64'd0);
        rr_if.out_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(rr_if.in_ready), 64'b0001);

        // Round-robin rotation with all channels held valid.
        for (int i = 0; i < 8; i++) begin
            step();
            expect_out("rotate", 2'(i % 4), 64'h1000 + 64'(i % 4));
        end
        drain_rr();
        check("rotate_ptr", 64'(u_rr.rr_ptr_q), 64'd0);

        // Single channel request on ch2.
        set_rr(2, 64'h1234);
        rr_if.in_valid = 4'b0100;
        #1;
        check("single_ready", 64'(rr_if.in_ready), 64'b0100);
        step();
        expect_out("single", 2'd2, 64'h1234);
        check("single_ptr", 64'(u_rr.rr_ptr_q), 64'd3);
        rr_if.in_valid = 4'b0000;
        step();
        check("idle_valid", 64'(rr_if.out_valid), 64'd0);
        check("idle_ptr",   64'(u_rr.rr_ptr_q),   64'd3);

        // Wrap search from rr_ptr=3.
        set_rr(0, 64'hA0);
        set_rr(1, 64'hA1);
        rr_if.in_valid = 4'b0011;
        #1;
        check("wrap_ready0", 64'(rr_if.in_ready), 64'b0001);
        step();
        expect_out("wrap0", 2'd0, 64'hA0);
        check("wrap_ptr1", 64'(u_rr.rr_ptr_q), 64'd1);
        rr_if.in_valid[0] = 1'b0;
        #1;
        check("wrap_ready1", 64'(rr_if.in_ready), 64'b0010);
        step();
        expect_out("wrap1", 2'd1, 64'hA1);
        check("wrap_ptr2", 64'(u_rr.rr_ptr_q), 64'd2);
        rr_if.in_valid = 4'b0000;
        step();
        check("wrap_idle", 64'(rr_if.out_valid), 64'd0);

        // Backpressure: hold ch1/0x55 for 5 cycles, then drain-and-load.
        rr_if.out_ready = 1'b0;
        set_rr(1, 64'h55);
        rr_if.in_valid = 4'b0010;
        #1;
        check("bp_load_ready", 64'(rr_if.in_ready), 64'b0010);
        step();
        expect_out("bp_load", 2'd1, 64'h55);
        rr_if.in_valid = 4'b1111;
        for (int n = 0; n < 4; n++) set_rr(n, 64'hB0 + 64'(n));
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ready", 64'(rr_if.in_ready), 64'd0);
            step();
            expect_out("bp_hold", 2'd1, 64'h55);
            check("bp_ptr", 64'(u_rr.rr_ptr_q), 64'd2);
        end
        rr_if.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(rr_if.in_ready), 64'b0100);
        step();
        expect_out("bp_swap", 2'd2, 64'hB2);
        check("bp_swap_ptr", 64'(u_rr.rr_ptr_q), 64'd3);
        rr_if.in_valid[2] = 1'b0;
        drain_rr();
        step();
        check("bp_idle", 64'(rr_if.out_valid), 64'd0);

        // Fixed priority: ch1 starves ch3 until it drops.
        set_fp(1, 64'hC1);
        set_fp(3, 64'hC3);
        fp_if.in_valid = 4'b1010;
        #1;
        check("fp_ready", 64'(fp_if.in_ready), 64'b0010);
        for (int i = 0; i < 4; i++) begin
            step();
            check("fp_ch",    64'(fp_if.out_ch),    64'd1);
            check("fp_data",  fp_if.out_data,       64'hC1);
            check("fp_ready_hold", 64'(fp_if.in_ready), 64'b0010);
        end
        fp_if.in_valid[1] = 1'b0;
        #1;
        check("fp_ready3", 64'(fp_if.in_ready), 64'b1000);
        step();
        check("fp_ch3",    64'(fp_if.out_ch),    64'd3);
        check("fp_data3",  fp_if.out_data,       64'hC3);
        check("fp_valid3", 64'(fp_if.out_valid), 64'd1);
        fp_if.in_valid = 4'b0000;
        step();
        check("fp_idle", 64'(fp_if.out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
